t_param_mask_rr_arb: RTL
========================

# t_param_mask_rr_arb

Round-robin arbiter that shares one resource between `N` requesters. The set of requesters allowed to win is fixed by a parameter bit-mask. Each mask bit is read with a constant bit-select, including the `N=1` case where the mask is a 1-bit sized parameter such as `1'b1`. The block sits in the regression suite as a self-contained sequential design: a bench drives requests, checks grants, and ends with `$finish` on success or `$stop` on mismatch.

## Interface
Parameters:
- `N`, 4: number of requesters; legal range 1..16.
- `EN_MASK`, `4'b1111`: bit `i` enables requester `i`.
  - Read only as `EN_MASK[i]`.
  - With `N=1` it is given as `1'b0` or `1'b1` and is bit-selected as `EN_MASK[0]`, i.e. treated as a 1-bit vector, never as a scalar.
- `HOLD_MAX`, 8: maximum consecutive cycles one grant is held; must be ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N  request per requester; level-sensitive.
- `done`  in  N  release strobe per requester; only the owner's bit is honoured.
- `gnt`  out  N  one-hot grant, registered.
- `gnt_valid`  out  1  OR of `gnt`, registered.
- `gnt_id`  out  IW  index of the owner.
  - IW = 1 if `N`==1, else `$clog2(N)`.
  - 0 when no grant.
- `timeout`  out  1  one-cycle pulse when a grant is force-released by `HOLD_MAX`.
- `grant_cnt`  out  16  number of grants issued since reset; saturates at 16'hFFFF.

## Operation
- Effective request: `eff[i] = req[i] & EN_MASK[i]`.
  - A masked requester is never granted, whatever its `req` level.
- State: FSM {IDLE, GRANT}, round-robin pointer `ptr` (IW bits), hold counter `hcnt`, owner register.
- IDLE:
  - If `eff` is nonzero, the winner is the first set bit of `eff` at index ≥`ptr`, wrapping to index 0.
  - On the edge that picks the winner: `gnt`/`gnt_id`/`gnt_valid` load, `hcnt` clears to 0, `grant_cnt` increments (saturating), state becomes GRANT.
  - If `eff` is zero, stay in IDLE with all grant outputs 0.
- GRANT:
  - Each edge, `hcnt` increments.
  - Release occurs on the first edge where any of these holds:
    - (a) `done[owner]`=1;
    - (b) `req[owner]`=0;
    - (c) `hcnt`==`HOLD_MAX`-1.
  - On release: `gnt`, `gnt_id` and `gnt_valid` clear to 0; `ptr` ← (owner+1) mod `N`; state becomes IDLE.
  - If (c) is the only cause, `timeout`=1 for exactly that cycle. If (a) or (b) hold on the same edge, `timeout` stays 0.
- `done`/`req` changes on non-owner bits are ignored while in GRANT.
- The IDLE cycle after every release is mandatory. A requester cannot be granted back-to-back without at least one cycle of `gnt`=0 in between.
- `N`=1: `ptr` is stuck at 0. The single requester is re-granted after each one-cycle gap while `req[0]` and `EN_MASK[0]` are 1.
- `EN_MASK` all zero: the block never leaves IDLE; legal, not an error.
- Reset (`rst`=1, asynchronous, at any time including mid-grant):
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `timeout`=0, `grant_cnt`=0.
  - `ptr`=0, `hcnt`=0, state IDLE.
  - All take effect immediately, without waiting for a clock edge.
  - The first edge after `rst` falls evaluates IDLE normally.

## Timing
- Request to grant: `req` sampled at edge E gives `gnt` valid after E (1-cycle latency from sampling).
- Grant length:
  - Equals the number of edges until the release condition, counted from the grant edge.
  - Maximum `HOLD_MAX` cycles high.
  - `HOLD_MAX`=1 gives exactly one cycle high and `timeout` pulsing on the cycle `gnt` falls.
- Release to next grant: `gnt` is low for exactly one cycle when other effective requests are pending.
- `timeout` is coincident with the first `gnt`=0 cycle after a forced release.
- `grant_cnt` updates on the same edge `gnt` rises.

## Test plan
1. `N`=4, `EN_MASK`=4'b1111, `HOLD_MAX`=8, `req`=4'b1111 held, `done`=0 → grants to 0,1,2,3,0.
   - Each grant is 8 cycles high, followed by a 1-cycle gap.
   - `timeout` pulses 5 times.
   - `grant_cnt`=5.
2. `N`=1, `EN_MASK`=1'b1, `req`=1, `done[0]` pulsed 3 cycles after grant → `gnt`=1 for 3 cycles, `gnt_id`=0, 1 cycle low, then re-granted.
   - Repeat with `EN_MASK`=1'b0 → `gnt` stays 0 for 20 cycles.
3. `N`=4, `EN_MASK`=4'b0101, `req`=4'b1111, `done` pulsed 2 cycles into each grant → owner sequence 0,2,0,2; requesters 1 and 3 are never granted.
4. Owner 1 granted with `req`=4'b0110 → pulse `done[3]`: no change. Pulse `done[1]`: `gnt`=0 next cycle, then `gnt`=4'b0100 (`gnt_id`=2), `timeout` stays 0.
5. `rst` asserted mid-grant between clock edges → `gnt`, `gnt_valid`, `grant_cnt` go to 0 before the next edge.
   - After release with `req`=4'b1000, first grant goes to 3 one edge later; `grant_cnt`=1.
6. Owner drops `req` at the same edge `hcnt` reaches `HOLD_MAX`-1 → release, `timeout`=0. The bench prints "*-* All Finished *-*" and calls `$finish`; any mismatch calls `$stop`.

Source files
------------

// File: rtl/t_param_mask_rr_arb.sv
// Round-robin arbiter over N requesters with a parameter enable mask,
// bounded grant hold time and a mandatory idle cycle after every release.
module t_param_mask_rr_arb #(
    parameter int             N        = 4,
    parameter logic [N-1:0]   EN_MASK  = 4'b1111,
    parameter int             HOLD_MAX = 8,
    localparam int            IW       = (N == 1) ? 1 : $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic          timeout,
    output logic [15:0]   grant_cnt
);

    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     grant_cnt_q, grant_cnt_d;

    logic [N-1:0]    eff;
    logic            any_found, hi_found;
    logic [IW-1:0]   lo_idx, hi_idx, winner;
    logic            owner_done, owner_req, hold_hit;

    for (genvar g = 0; g < N; g++) begin : g_eff
        assign eff[g] = req[g] & EN_MASK[g];
    end

    // Descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        any_found = 1'b0;
        lo_idx    = '0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eff[i]) begin
                any_found = 1'b1;
                lo_idx    = IW'(i);
                if (IW'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hcnt_d      = hcnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        grant_cnt_d = grant_cnt_q;
        winner      = hi_found ? hi_idx : lo_idx;
        owner_done  = |(done & gnt_q);
        owner_req   = |(req & gnt_q);
        hold_hit    = (hcnt_q == HW'(HOLD_MAX - 1));
        unique case (state_q)
            S_IDLE: begin
                if (any_found) begin
                    state_d     = S_GRANT;
                    gnt_d       = N'(1) << winner;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    hcnt_d      = '0;
                    if (grant_cnt_q != 16'hFFFF) begin
                        grant_cnt_d = grant_cnt_q + 16'd1;
                    end
                end
            end
            S_GRANT: begin
                hcnt_d = hcnt_q + HW'(1);
                if (owner_done || !owner_req || hold_hit) begin
                    state_d     = S_IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + IW'(1);
                    // Forced release flagged only when the owner still wanted the resource.
                    timeout_d   = hold_hit && !owner_done && owner_req;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            hcnt_q      <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hcnt_q      <= hcnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
    assign grant_cnt = grant_cnt_q;

endmodule
